// File: rtl/func_unit_ls.sv
// func_unit_ls: single-entry, non-pipelined load/store unit.
// Accepts one LDUR/STUR from the reservation station. Performs the access over a
// req/ack memory port. Returns the tagged result to the ROB under a grant handshake.
module func_unit_ls #(
  parameter int          ADDR_ALIGN_BITS = 3,
  parameter int          GPR_SIZE        = 64,
  parameter int          ROB_IDX_SIZE    = 6,
  parameter int          OP_SIZE         = 4,
  parameter int unsigned FU_OP_LDUR      = 1,
  parameter int unsigned FU_OP_STUR      = 2
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rs_start,
  input  logic [OP_SIZE-1:0]      in_rs_op,
  input  logic [GPR_SIZE-1:0]     in_rs_val_a,
  input  logic [GPR_SIZE-1:0]     in_rs_val_b,
  input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
  input  logic                    in_rob_is_mispred,
  output logic                    out_fu_ready,
  output logic                    out_mem_req,
  output logic                    out_mem_we,
  output logic [GPR_SIZE-1:0]     out_mem_addr,
  output logic [GPR_SIZE-1:0]     out_mem_wdata,
  input  logic                    in_mem_ack,
  input  logic [GPR_SIZE-1:0]     in_mem_rdata,
  output logic                    out_rob_done,
  output logic [GPR_SIZE-1:0]     out_rob_value,
  output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
  output logic                    out_rob_fault,
  input  logic                    in_rob_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_SIZE-1:0] OP_LD = FU_OP_LDUR[OP_SIZE-1:0];
  localparam logic [OP_SIZE-1:0] OP_ST = FU_OP_STUR[OP_SIZE-1:0];

  state_t                  state;
  logic                    squash;
  logic                    is_store;
  logic [ROB_IDX_SIZE-1:0] tag_q;

  logic op_is_ld;
  logic op_is_st;

  // Low address bits must be zero; otherwise the access faults without touching memory.
  function automatic logic is_misaligned(input logic [GPR_SIZE-1:0] addr);
    return addr[ADDR_ALIGN_BITS-1:0] != '0;
  endfunction

  // Decode the issued opcode; anything other than LDUR/STUR is ignored.
  always_comb begin
    op_is_ld = (in_rs_op == OP_LD);
    op_is_st = (in_rs_op == OP_ST);
  end

  assign out_fu_ready = (state == IDLE);

  // Control FSM with registered memory-port and ROB-port outputs.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state                 <= IDLE;
      squash                <= 1'b0;
      is_store              <= 1'b0;
      tag_q                 <= '0;
      out_mem_req           <= 1'b0;
      out_mem_we            <= 1'b0;
      out_mem_addr          <= '0;
      out_mem_wdata         <= '0;
      out_rob_done          <= 1'b0;
      out_rob_value         <= '0;
      out_rob_dst_rob_index <= '0;
      out_rob_fault         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A start coinciding with a mispredict belongs to the squashed path.
          if (in_rs_start && !in_rob_is_mispred && (op_is_ld || op_is_st)) begin
            is_store <= op_is_st;
            tag_q    <= in_rs_dst_rob_index;
            if (is_misaligned(in_rs_val_a)) begin
              state                 <= RESP;
              out_rob_done          <= 1'b1;
              out_rob_value         <= '0;
              out_rob_fault         <= 1'b1;
              out_rob_dst_rob_index <= in_rs_dst_rob_index;
            end else begin
              state         <= REQ;
              out_mem_req   <= 1'b1;
              out_mem_we    <= op_is_st;
              out_mem_addr  <= in_rs_val_a;
              out_mem_wdata <= op_is_st ? in_rs_val_b : '0;
            end
          end
        end
        REQ: begin
          // The memory handshake always completes; a mispredict only marks the result dead.
          if (in_rob_is_mispred) begin
            squash <= 1'b1;
          end
          if (in_mem_ack) begin
            out_mem_req   <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_addr  <= '0;
            out_mem_wdata <= '0;
            if (squash || in_rob_is_mispred) begin
              state  <= IDLE;
              squash <= 1'b0;
            end else begin
              state                 <= RESP;
              out_rob_done          <= 1'b1;
              out_rob_value         <= is_store ? '0 : in_mem_rdata;
              out_rob_fault         <= 1'b0;
              out_rob_dst_rob_index <= tag_q;
            end
          end
        end
        RESP: begin
          // Grant consumes the result; a mispredict drops it. Either way, return to idle.
          if (in_rob_grant || in_rob_is_mispred) begin
            state                 <= IDLE;
            squash                <= 1'b0;
            out_rob_done          <= 1'b0;
            out_rob_value         <= '0;
            out_rob_fault         <= 1'b0;
            out_rob_dst_rob_index <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          squash <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_func_unit_ls.sv
// Directed testbench for func_unit_ls with hand-computed expected values.
module tb_func_unit_ls;

  localparam int GPR_SIZE     = 64;
  localparam int ROB_IDX_SIZE = 6;
  localparam int OP_SIZE      = 4;
  localparam logic [OP_SIZE-1:0] OP_LD  = 4'd1;
  localparam logic [OP_SIZE-1:0] OP_ST  = 4'd2;
  localparam logic [OP_SIZE-1:0] OP_BAD = 4'd7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    rs_start = 1'b0;
  logic [OP_SIZE-1:0]      rs_op = '0;
  logic [GPR_SIZE-1:0]     rs_val_a = '0;
  logic [GPR_SIZE-1:0]     rs_val_b = '0;
  logic [ROB_IDX_SIZE-1:0] rs_tag = '0;
  logic                    mispred = 1'b0;
  logic                    fu_ready;
  logic                    mem_req;
  logic                    mem_we;
  logic [GPR_SIZE-1:0]     mem_addr;
  logic [GPR_SIZE-1:0]     mem_wdata;
  logic                    mem_ack = 1'b0;
  logic [GPR_SIZE-1:0]     mem_rdata = '0;
  logic                    rob_done;
  logic [GPR_SIZE-1:0]     rob_value;
  logic [ROB_IDX_SIZE-1:0] rob_tag;
  logic                    rob_fault;
  logic                    rob_grant = 1'b0;

  int checks = 0;
  int errors = 0;

  func_unit_ls #(
    .ADDR_ALIGN_BITS(3),
    .GPR_SIZE(GPR_SIZE),
    .ROB_IDX_SIZE(ROB_IDX_SIZE),
    .OP_SIZE(OP_SIZE),
    .FU_OP_LDUR(1),
    .FU_OP_STUR(2)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .in_rs_start(rs_start),
    .in_rs_op(rs_op),
    .in_rs_val_a(rs_val_a),
    .in_rs_val_b(rs_val_b),
    .in_rs_dst_rob_index(rs_tag),
    .in_rob_is_mispred(mispred),
    .out_fu_ready(fu_ready),
    .out_mem_req(mem_req),
    .out_mem_we(mem_we),
    .out_mem_addr(mem_addr),
    .out_mem_wdata(mem_wdata),
    .in_mem_ack(mem_ack),
    .in_mem_rdata(mem_rdata),
    .out_rob_done(rob_done),
    .out_rob_value(rob_value),
    .out_rob_dst_rob_index(rob_tag),
    .out_rob_fault(rob_fault),
    .in_rob_grant(rob_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OP_SIZE-1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [ROB_IDX_SIZE-1:0] t);
    rs_start = 1'b1;
    rs_op    = op;
    rs_val_a = a;
    rs_val_b = b;
    rs_tag   = t;
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_ready", 64'(fu_ready), 64'd1);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_done", 64'(rob_done), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    rst = 1'b0;
    tick();

    // Load, ack on third REQ cycle, immediate grant
    issue(OP_LD, 64'h40, 64'h0, 6'd5);
    tick();
    rs_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", 64'(mem_req), 64'd1);
      chk("ld_we", 64'(mem_we), 64'd0);
      chk("ld_addr", mem_addr, 64'h40);
      chk("ld_ready", 64'(fu_ready), 64'd0);
      chk("ld_done_early", 64'(rob_done), 64'd0);
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 64'hDEAD;
      end
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("ld_req_off", 64'(mem_req), 64'd0);
    chk("ld_done", 64'(rob_done), 64'd1);
    chk("ld_value", rob_value, 64'hDEAD);
    chk("ld_tag", 64'(rob_tag), 64'd5);
    chk("ld_fault", 64'(rob_fault), 64'd0);
    rob_grant = 1'b1;
    tick();
    rob_grant = 1'b0;
    chk("ld_done_off", 64'(rob_done), 64'd0);
    chk("ld_ready_back", 64'(fu_ready), 64'd1);

    // Store, ack in first cycle, grant delayed 4 cycles
    issue(OP_ST, 64'h10, 64'd42, 6'd3);
    tick();
    rs_start = 1'b0;
    chk("st_req", 64'(mem_req), 64'd1);
    chk("st_we", 64'(mem_we), 64'd1);
    chk("st_addr", mem_addr, 64'h10);
    chk("st_wdata", mem_wdata, 64'd42);
    mem_ack   = 1'b1;
    mem_rdata = 64'hFFFF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("st_req_off", 64'(mem_req), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("st_done", 64'(rob_done), 64'd1);
      chk("st_value", rob_value, 64'd0);
      chk("st_tag", 64'(rob_tag), 64'd3);
      tick();
    end
    rob_grant = 1'b1;
    tick();
    rob_grant = 1'b0;
    chk("st_done_off", 64'(rob_done), 64'd0);
    chk("st_ready_back", 64'(fu_ready), 64'd1);

    // Misaligned load faults without a memory request
    issue(OP_LD, 64'h44, 64'h0, 6'd7);
    tick();
    rs_start = 1'b0;
    chk("mis_req", 64'(mem_req), 64'd0);
    chk("mis_done", 64'(rob_done), 64'd1);
    chk("mis_fault", 64'(rob_fault), 64'd1);
    chk("mis_value", rob_value, 64'd0);
    chk("mis_tag", 64'(rob_tag), 64'd7);
    rob_grant = 1'b1;
    tick();
    rob_grant = 1'b0;
    chk("mis_done_off", 64'(rob_done), 64'd0);
    chk("mis_fault_off", 64'(rob_fault), 64'd0);

    // Mispredict while waiting for ack
    issue(OP_LD, 64'h80, 64'h0, 6'd2);
    tick();
    rs_start = 1'b0;
    mispred  = 1'b1;
    tick();
    mispred  = 1'b0;
    chk("sq_req_held", 64'(mem_req), 64'd1);
    chk("sq_addr_held", mem_addr, 64'h80);
    tick();
    chk("sq_req_held2", 64'(mem_req), 64'd1);
    mem_ack   = 1'b1;
    mem_rdata = 64'h1234;
    tick();
    mem_ack   = 1'b0;
    chk("sq_req_off", 64'(mem_req), 64'd0);
    chk("sq_no_done", 64'(rob_done), 64'd0);
    chk("sq_ready", 64'(fu_ready), 64'd1);
    tick();
    chk("sq_no_done2", 64'(rob_done), 64'd0);

    // Invalid opcode is ignored
    issue(OP_BAD, 64'h8, 64'h0, 6'd1);
    tick();
    rs_start = 1'b0;
    chk("bad_ready", 64'(fu_ready), 64'd1);
    chk("bad_req", 64'(mem_req), 64'd0);
    chk("bad_done", 64'(rob_done), 64'd0);

    // Mispredict in RESP drops the result
    issue(OP_LD, 64'h3, 64'h0, 6'd4);
    tick();
    rs_start = 1'b0;
    chk("rsq_done", 64'(rob_done), 64'd1);
    mispred = 1'b1;
    tick();
    mispred = 1'b0;
    chk("rsq_done_off", 64'(rob_done), 64'd0);
    chk("rsq_ready", 64'(fu_ready), 64'd1);

    // Start held high: only accepted in IDLE
    issue(OP_LD, 64'h100, 64'h0, 6'd9);
    tick();
    rs_val_a = 64'h200;
    rs_tag   = 6'd11;
    chk("bp_addr0", mem_addr, 64'h100);
    tick();
    chk("bp_addr1", mem_addr, 64'h100);
    chk("bp_ready", 64'(fu_ready), 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 64'h55;
    tick();
    mem_ack   = 1'b0;
    chk("bp_value", rob_value, 64'h55);
    chk("bp_tag", 64'(rob_tag), 64'd9);
    tick();
    chk("bp_done_held", 64'(rob_done), 64'd1);
    chk("bp_tag_held", 64'(rob_tag), 64'd9);
    chk("bp_req_resp", 64'(mem_req), 64'd0);
    rob_grant = 1'b1;
    tick();
    rob_grant = 1'b0;
    chk("bp_ready_idle", 64'(fu_ready), 64'd1);
    chk("bp_done_off", 64'(rob_done), 64'd0);
    tick();
    rs_start = 1'b0;
    chk("bp_req2", 64'(mem_req), 64'd1);
    chk("bp_addr2", mem_addr, 64'h200);
    mem_ack   = 1'b1;
    mem_rdata = 64'h77;
    tick();
    mem_ack   = 1'b0;
    chk("bp_tag2", 64'(rob_tag), 64'd11);
    chk("bp_done2", 64'(rob_done), 64'd1);

    // Reset while done is high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_done", 64'(rob_done), 64'd0);
    chk("rr_ready", 64'(fu_ready), 64'd1);
    chk("rr_value", rob_value, 64'd0);
    chk("rr_tag", 64'(rob_tag), 64'd0);
    chk("rr_fault", 64'(rob_fault), 64'd0);
    chk("rr_req", 64'(mem_req), 64'd0);
    chk("rr_wdata", mem_wdata, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/func_unit_ls.md
# func_unit_ls

Load/store functional unit. It sits directly downstream of the LS reservation station and consumes one issued LDUR/STUR per handshake. It performs the access over a variable-latency req/ack data-memory port and returns the result, tagged with the destination ROB index, to the ROB broadcast path under a grant handshake. It is single-entry and non-pipelined; `out_fu_ready` back-pressures the reservation station.

## Interface
Parameters:
- `ADDR_ALIGN_BITS`, 3: low address bits that must be zero; a nonzero value raises a fault and skips memory.

Ports:
- `in_clk` in 1: clock, rising edge.
- `in_rst` in 1: synchronous, active-high reset.
- `in_rs_start` in 1: RS issues an op this cycle.
- `in_rs_op` in fu_op_t: FU_OP_LDUR or FU_OP_STUR.
- `in_rs_val_a` in `GPR_SIZE`: effective address (base+offset already summed upstream).
- `in_rs_val_b` in `GPR_SIZE`: store data; ignored for loads.
- `in_rs_dst_rob_index` in `ROB_IDX_SIZE`: result tag.
- `in_rob_is_mispred` in 1: squash the in-flight op.
- `out_fu_ready` out 1: unit idle, can accept.
- `out_mem_req` out 1: memory request valid.
- `out_mem_we` out 1: 1 = store.
- `out_mem_addr` out `GPR_SIZE`: access address.
- `out_mem_wdata` out `GPR_SIZE`: store data.
- `in_mem_ack` in 1: memory accepted/completed the request; for loads, rdata is valid the same cycle.
- `in_mem_rdata` in `GPR_SIZE`: load data.
- `out_rob_done` out 1: result valid.
- `out_rob_value` out `GPR_SIZE`: load data; 0 for stores and faults.
- `out_rob_dst_rob_index` out `ROB_IDX_SIZE`: result tag.
- `out_rob_fault` out 1: misaligned access.
- `in_rob_grant` in 1: result consumed this cycle.

## Operation
- FSM states: IDLE, REQ, RESP.
- `out_fu_ready` = (state==IDLE), combinational.
- IDLE: on `in_rs_start`, latch op, address, data and tag.
  - If `in_rs_op` is not LDUR/STUR: ignore the start and stay in IDLE.
  - If the address is misaligned (`addr[ADDR_ALIGN_BITS-1:0]` != 0): go to RESP with fault=1, value=0.
  - Otherwise: go to REQ.
- REQ: drive `out_mem_req`=1, with `we`/`addr`/`wdata` held stable until `in_mem_ack`.
  - On ack: capture `in_mem_rdata` (loads) or 0 (stores) into the value register, then go to RESP.
- RESP: `out_rob_done`=1 with value, tag and fault held stable until `in_rob_grant`. On grant, go to IDLE.
- Mispredict (`in_rob_is_mispred` high at an edge):
  - IDLE: no effect. A start in the same cycle is dropped.
  - REQ before ack: the request stays asserted until ack. Memory handshakes are never abandoned. Set a squash flag; on ack, go to IDLE without entering RESP.
  - REQ with ack in the same cycle: same as above. The ack completes the bus handshake and the result is discarded.
  - RESP: drop the result and go to IDLE on the next edge, regardless of grant.
- Squash flag clears on entry to IDLE.
- Output registers with no valid content are driven to 0.
- Reset: state=IDLE, squash=0.
  - Outputs: `out_mem_req`=0, `out_mem_we`=0, `out_mem_addr`=0, `out_mem_wdata`=0, `out_rob_done`=0, `out_rob_value`=0, `out_rob_dst_rob_index`=0, `out_rob_fault`=0, `out_fu_ready`=1.
  - Reset overrides start, ack and mispredict in the same cycle.
  - Reset mid-REQ drops `out_mem_req` on the next edge. Reset must only be asserted with memory quiescent.

## Timing
- Start accepted at edge T (start & ready). `out_mem_req` is high from T through the ack edge.
- Ack at edge T+k: `out_rob_done` is high from T+k until the grant edge.
- Minimum latency, start to done, is 2 edges (ack in the first REQ cycle).
- Fault path: done asserted 1 edge after start.
- Earliest next accept is the edge after the grant edge, since ready is high from the grant edge onward. Throughput is at most 1 op per 3 cycles.
- Simultaneous grant and mispredict in RESP: go to IDLE; the result counts as consumed by the grant.

## Test plan
- Load, ack after 3 REQ cycles, immediate grant. Start LDUR addr=0x40, tag=5, rdata=0xDEAD.
  - Required: req high 3 cycles with we=0, addr=0x40.
  - Then done with value=0xDEAD, tag=5, fault=0; ready again after grant.
- Store, ack in first cycle, grant delayed 4 cycles. Start STUR addr=0x10, data=42.
  - Required: req for 1 cycle with we=1, wdata=42.
  - Then done with value=0 held 4 cycles, stable, until grant.
- Misaligned load. Start LDUR addr=0x44.
  - Required: no req ever. Done next cycle with fault=1, value=0.
- Mispredict while waiting. LDUR issued; mispred pulsed in REQ; ack 2 cycles later.
  - Required: req held until ack, no done ever, ready after ack.
- Back-pressure and ignored start. `in_rs_start` held high continuously.
  - Required: a new op is accepted only in IDLE cycles; start is ignored in REQ/RESP, and the latched addr/tag are unchanged.
- Reset in RESP with done high.
  - Required: next edge done=0, ready=1, all outputs zero.
